full_adder: RTL and testbench

Registered full adder: adds operands a and b plus carry-in cin, and registers the sum and carry-out.
- Default WIDTH=1 gives the classic single-bit full adder (S, Cout). Wider instances form a ripple-carry adder built from 1-bit cells.
- Used as a leaf arithmetic primitive inside datapaths.
- One cycle of latency, with a valid strobe alongside the data.

---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 18 +
 rtl/full_adder.sv | 79 +++++++
 tb/tb_full_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and golden reference model for the full_adder block.
package full_adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    // Returns {carry_out, sum} at the maximum width; callers slice to their WIDTH.
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin
    );
        return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell, the ripple-chain building block of full_adder.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_half;

    assign w_half = a ^ b;
    assign s      = w_half ^ ci;
    assign co     = (a & b) | (ci & w_half);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder with one cycle of latency and a valid strobe.
// Define FULL_ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
`ifdef FULL_ADDER_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_carry[i]),
            .s  (w_sum[i]),
            .co (w_carry[i+1])
        );
    end

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_valid;

    // Result registers only load on in_valid, so X operands while idle never propagate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s    <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign ovf = r_ovf;
`endif

    assign s         = r_s;
    assign cout      = r_cout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a WIDTH=1 and a WIDTH=8 instance with scoreboards.
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic       i1_valid = 1'b0, i1_a = 1'b0, i1_b = 1'b0, i1_cin = 1'b0;
    logic       o1_valid, o1_s, o1_cout, o1_ovf;
    logic       i8_valid = 1'b0, i8_cin = 1'b0;
    logic [7:0] i8_a = '0, i8_b = '0;
    logic       o8_valid, o8_cout, o8_ovf;
    logic [7:0] o8_s;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (i1_valid),
        .a         (i1_a),
        .b         (i1_b),
        .cin       (i1_cin),
        .out_valid (o1_valid),
        .s         (o1_s),
`ifdef FULL_ADDER_OVERFLOW_EN
        .ovf       (o1_ovf),
`endif
        .cout      (o1_cout)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (i8_valid),
        .a         (i8_a),
        .b         (i8_b),
        .cin       (i8_cin),
        .out_valid (o8_valid),
        .s         (o8_s),
`ifdef FULL_ADDER_OVERFLOW_EN
        .ovf       (o8_ovf),
`endif
        .cout      (o8_cout)
    );

`ifndef FULL_ADDER_OVERFLOW_EN
    assign o1_ovf = 1'b0;
    assign o8_ovf = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Stimulus only: drive a 1-bit operand set and push the expected result.
    task automatic drive1(input logic a, input logic b, input logic c,
                          input logic exp_s, input logic exp_cout);
        exp_t e;
        i1_valid = 1'b1; i1_a = a; i1_b = b; i1_cin = c;
        e.s    = {7'b0, exp_s};
        e.cout = exp_cout;
        e.ovf  = (a == b) && (exp_s != a);
        q1.push_back(e);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t       e;
        logic [8:0] sum;
        i8_valid = 1'b1; i8_a = a; i8_b = b; i8_cin = c;
        sum    = {1'b0, a} + {1'b0, b} + {8'b0, c};
        e.s    = sum[7:0];
        e.cout = sum[8];
        e.ovf  = (a[7] == b[7]) && (sum[7] != a[7]);
        q8.push_back(e);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({o1_valid, o1_cout, o1_s, o1_ovf} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_w1: got valid=%b cout=%b s=%b ovf=%b, want all 0",
                     o1_valid, o1_cout, o1_s, o1_ovf);
        end
        n_tests++;
        if ({o8_valid, o8_cout, o8_s, o8_ovf} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_w8: got valid=%b cout=%b s=%h ovf=%b, want all 0",
                     o8_valid, o8_cout, o8_s, o8_ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table;
        logic [2:0] vin [8];
        logic [1:0] vout[8];
        exp_t       e;
        vin  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        vout = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = q1.pop_front();
                n_tests++;
                if ({o1_valid, o1_cout, o1_s} !== {1'b1, e.cout, e.s[0]}) begin
                    n_fail++;
                    $display("FAIL truth_table[%0d]: got valid=%b cout=%b s=%b, want 1 %b %b",
                             i - 1, o1_valid, o1_cout, o1_s, e.cout, e.s[0]);
                end
`ifdef FULL_ADDER_OVERFLOW_EN
                n_tests++;
                if (o1_ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL truth_table_ovf[%0d]: got %b want %b", i - 1, o1_ovf, e.ovf);
                end
`endif
            end
            if (i < 8) drive1(vin[i][2], vin[i][1], vin[i][0], vout[i][1], vout[i][0]);
            else i1_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        i1_valid = 1'b0;
        e = q1.pop_front();
        n_tests++;
        if ({o1_valid, o1_cout, o1_s} !== {1'b1, e.cout, e.s[0]}) begin
            n_fail++;
            $display("FAIL areset_load: got valid=%b cout=%b s=%b, want 1 1 1",
                     o1_valid, o1_cout, o1_s);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o1_valid, o1_cout, o1_s, o1_ovf} !== 4'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got valid=%b cout=%b s=%b ovf=%b, want all 0",
                     o1_valid, o1_cout, o1_s, o1_ovf);
        end
        q1.delete();
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({o1_valid, o1_cout, o1_s, o1_ovf} !== 4'b0) begin
                n_fail++;
                $display("FAIL areset_after[%0d]: got valid=%b cout=%b s=%b ovf=%b, want all 0",
                         k, o1_valid, o1_cout, o1_s, o1_ovf);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        e = q1.pop_front();
        n_tests++;
        if ({o1_valid, o1_cout, o1_s} !== {1'b1, e.cout, e.s[0]}) begin
            n_fail++;
            $display("FAIL hold_load: got valid=%b cout=%b s=%b, want 1 %b %b",
                     o1_valid, o1_cout, o1_s, e.cout, e.s[0]);
        end
        i1_valid = 1'b0; i1_a = 1'bx; i1_b = 1'b1; i1_cin = 1'bx;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({o1_valid, o1_cout, o1_s, o1_ovf} !== {1'b0, e.cout, e.s[0], 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got valid=%b cout=%b s=%b ovf=%b, want 0 %b %b 0",
                         k, o1_valid, o1_cout, o1_s, o1_ovf, e.cout, e.s[0]);
            end
            i1_a = k[0]; i1_b = ~k[0]; i1_cin = (k == 1) ? 1'bx : 1'b1;
        end
        i1_a = 1'b0; i1_b = 1'b0; i1_cin = 1'b0;
    endtask

    // Two consecutive 8-bit operand sets, then an idle cycle checking that valid drops.
    task automatic run8_pair(input string name, input logic [7:0] a0, input logic [7:0] b0,
                             input logic c0, input logic [7:0] a1, input logic [7:0] b1,
                             input logic c1);
        exp_t e;
        @(negedge clk);
        drive8(a0, b0, c0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin
                e = q8.pop_front();
                n_tests++;
                if ({o8_valid, o8_cout, o8_s} !== {1'b1, e.cout, e.s}) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got valid=%b cout=%b s=%h, want 1 %b %h",
                             name, i, o8_valid, o8_cout, o8_s, e.cout, e.s);
                end
`ifdef FULL_ADDER_OVERFLOW_EN
                n_tests++;
                if (o8_ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL %s_ovf[%0d]: got %b want %b", name, i, o8_ovf, e.ovf);
                end
`endif
            end else begin
                n_tests++;
                if ({o8_valid, o8_cout, o8_s} !== {1'b0, e.cout, e.s}) begin
                    n_fail++;
                    $display("FAIL %s_idle: got valid=%b cout=%b s=%h, want 0 %b %h",
                             name, o8_valid, o8_cout, o8_s, e.cout, e.s);
                end
            end
            if (i == 0) drive8(a1, b1, c1);
            else        i8_valid = 1'b0;
        end
    endtask

    task automatic test_wide_wrap;
        run8_pair("wide_wrap", 8'hFF, 8'h01, 1'b0, 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back;
        run8_pair("back_to_back", 8'h12, 8'h34, 1'b0, 8'h80, 8'h80, 1'b1);
    endtask

    task automatic test_overflow;
        run8_pair("overflow", 8'h7F, 8'h01, 1'b0, 8'h80, 8'h80, 1'b0);
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_async_reset();
        test_hold();
        test_wide_wrap();
        test_back_to_back();
        test_overflow();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
